// File: rtl/clk_monitor.sv
// clk_monitor: receive-side checker for a divided clock.
// Runs on clk_100MHz and treats clk_in as an asynchronous input. It synchronizes
// clk_in, emits edge pulses, measures the rise-to-rise period in fast cycles and
// reports lock or fault through a small state machine (IDLE/ACQUIRE/LOCKED/FAULT).
//
// Optional feature macro: CLKMON_DUTY_EN adds the high_time output and the duty
// check (fault code 11). Without it, code 11 never occurs.
//
// Ports:
//   clk_100MHz   in   system clock
//   reset_n      in   asynchronous active-low reset
//   clk_in       in   monitored clock, asynchronous
//   clear_fault  in   one-cycle request to leave FAULT
//   rise_pulse   out  one-cycle pulse per synchronized rising edge
//   fall_pulse   out  one-cycle pulse per synchronized falling edge
//   period       out  last measured rise-to-rise period (CNT_W)
//   period_valid out  one-cycle strobe when period updates
//   locked       out  high in LOCKED only
//   fault        out  high in FAULT only
//   fault_code   out  00 none, 01 range, 10 loss, 11 duty
//   high_time    out  cycles from rise to fall (CLKMON_DUTY_EN only)
module clk_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EXP_PERIOD  = 10,
  parameter int unsigned TOL         = 1,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT     = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             clk_in,
  input  logic             clear_fault,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code
`ifdef CLKMON_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_RANGE = 2'b01;
  localparam logic [1:0] CODE_LOSS  = 2'b10;
`ifdef CLKMON_DUTY_EN
  localparam logic [1:0] CODE_DUTY  = 2'b11;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic [CNT_W-1:0]       cnt;
  logic [GOOD_W-1:0]      good;
  logic                   period_good_c;
  logic                   duty_good_c;
  logic                   timeout_c;

  // Synchronizer chain; bit 0 samples the asynchronous clk_in.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
    end
  end

  // Edge detect against a registered copy of the last stage; pulses are registered.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_prev  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_prev  <= sync_q[SYNC_STAGES-1];
      rise_pulse <= sync_q[SYNC_STAGES-1] & ~sync_prev;
      fall_pulse <= ~sync_q[SYNC_STAGES-1] & sync_prev;
    end
  end

  // Period window check, done in 32 bits so EXP_PERIOD-TOL cannot underflow.
  always_comb begin
    period_good_c = ((32'(cnt) + TOL) >= EXP_PERIOD) && (32'(cnt) <= (EXP_PERIOD + TOL));
    timeout_c     = (cnt == CNT_W'(TIMEOUT));
  end

`ifdef CLKMON_DUTY_EN
  // High time is the counter value seen on the fall pulse (cycles since the rise).
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      high_time <= '0;
    end else if (fall_pulse) begin
      high_time <= cnt;
    end
  end

  always_comb begin
    duty_good_c = ((32'(high_time) + TOL) >= (EXP_PERIOD / 2)) &&
                  (32'(high_time) <= ((EXP_PERIOD / 2) + TOL));
  end
`else
  always_comb begin
    duty_good_c = 1'b1;
  end
`endif

  // Period counter, lock tracking and fault state machine.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      good         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= CODE_NONE;
    end else begin
      period_valid <= 1'b0;

      // Clearing a fault restarts the counter; a rise always restarts at 1.
      if (state == FAULT && clear_fault) begin
        cnt <= '0;
      end else if (rise_pulse) begin
        cnt <= CNT_W'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          // First rise only opens a measurement window; no period yet.
          if (rise_pulse) begin
            state <= ACQUIRE;
            good  <= '0;
          end
        end
        ACQUIRE: begin
          if (rise_pulse) begin
            period       <= cnt;
            period_valid <= 1'b1;
            if (period_good_c && duty_good_c) begin
              good <= good + GOOD_W'(1);
              if (good == GOOD_W'(LOCK_COUNT - 1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good <= '0;
            end
          end else if (timeout_c) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= CODE_LOSS;
          end
        end
        LOCKED: begin
          if (rise_pulse) begin
            period       <= cnt;
            period_valid <= 1'b1;
            // Range takes priority over duty on the same rise.
            if (!period_good_c) begin
              state      <= FAULT;
              locked     <= 1'b0;
              fault      <= 1'b1;
              fault_code <= CODE_RANGE;
            end
`ifdef CLKMON_DUTY_EN
            else if (!duty_good_c) begin
              state      <= FAULT;
              locked     <= 1'b0;
              fault      <= 1'b1;
              fault_code <= CODE_DUTY;
            end
`endif
          end else if (timeout_c) begin
            state      <= FAULT;
            locked     <= 1'b0;
            fault      <= 1'b1;
            fault_code <= CODE_LOSS;
          end
        end
        FAULT: begin
          // Sticky until cleared; period is frozen here.
          if (clear_fault) begin
            state      <= IDLE;
            good       <= '0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Bench for clk_monitor: table of clk_in segments with expected status after
// each, a scoreboard of driven rise-to-rise intervals checked against period,
// and hand-written lock/fault timing and asynchronous reset sequences.
module tb_clk_monitor;

  localparam int unsigned CNT_W = 8;

  logic             clk_100MHz;
  logic             reset_n;
  logic             clk_in;
  logic             clear_fault;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             fault;
  logic [1:0]       fault_code;
`ifdef CLKMON_DUTY_EN
  logic [CNT_W-1:0] high_time;
`endif

  clk_monitor dut (
    .clk_100MHz   (clk_100MHz),
    .reset_n      (reset_n),
    .clk_in       (clk_in),
    .clear_fault  (clear_fault),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .fault        (fault),
    .fault_code   (fault_code)
`ifdef CLKMON_DUTY_EN
    ,
    .high_time    (high_time)
`endif
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    int         hi;
    int         lo;
    int         n;
    bit         clr;
    bit         lock5;
    int         fdly;
    bit         exp_locked;
    bit         exp_fault;
    logic [1:0] exp_code;
  } row_t;

  row_t tbl[18];

  int errors = 0;
  int checks = 0;

  int sb[$];
  int cyc = 0;
  int last_drv = -1;
  bit pv_pend = 0;
  int pv_exp = 0;
  int rise_cnt = 0;
  int rise5_cyc = -1000;
  int lock_cyc = -1000;
  bit lock_seen = 0;
  int last_rp = -1000;
  int fault_cyc = -1000;
  int fault_rp = 0;
  bit fault_q = 0;
  int fall_drv = 0;
  int fall_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One fast cycle: observe outputs at the falling edge, then drive the next inputs.
  task automatic step(input logic v, input logic clr);
    int iv;
    @(negedge clk_100MHz);
    cyc++;
    if (period_valid) begin
      chk("valid_follows_rise", int'(pv_pend), 1);
      if (pv_pend) chk("period", int'(period), pv_exp);
    end
    pv_pend = 0;
    if (rise_pulse) begin
      chk("rise_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        pv_exp  = sb.pop_front();
        pv_pend = 1;
      end
      rise_cnt++;
      if (rise_cnt == 5) rise5_cyc = cyc;
      last_rp = cyc;
    end
    if (fall_pulse) fall_seen++;
    if (locked && !lock_seen) begin
      lock_seen = 1;
      lock_cyc  = cyc;
    end
    if (fault && !fault_q) begin
      fault_cyc = cyc;
      fault_rp  = last_rp;
    end
    fault_q = fault;
    if (v && !clk_in) begin
      iv = (last_drv < 0) ? 0 : cyc - last_drv;
      sb.push_back((iv > 255) ? 255 : iv);
      last_drv = cyc;
    end
    if (!v && clk_in) fall_drv++;
    clk_in      = v;
    clear_fault = clr;
  endtask

  task automatic drive_row(input int hi, input int lo, input int n, input bit clr);
    for (int k = 0; k < n; k++) begin
      for (int h = 0; h < hi; h++) step(1'b1, clr && (k == 0) && (h == 0));
      for (int l = 0; l < lo; l++) step(1'b0, 1'b0);
    end
  endtask

  task automatic set_row(input int i, input int hi, input int lo, input int n, input bit clr,
                         input bit lock5, input int fdly, input bit l, input bit f,
                         input logic [1:0] c);
    tbl[i].hi = hi; tbl[i].lo = lo; tbl[i].n = n; tbl[i].clr = clr;
    tbl[i].lock5 = lock5; tbl[i].fdly = fdly;
    tbl[i].exp_locked = l; tbl[i].exp_fault = f; tbl[i].exp_code = c;
  endtask

  initial begin
    //        idx hi  lo  n  clr l5 fdly  L  F  code
    set_row(0,  5,  5, 5, 0, 1, 0,  1, 0, 2'b00); // lock after 5th rise
    set_row(1,  5,  6, 1, 0, 0, 0,  1, 0, 2'b00);
    set_row(2,  5,  5, 2, 0, 0, 0,  1, 0, 2'b00); // period 11 within tolerance
    set_row(3,  5,  8, 1, 0, 0, 0,  1, 0, 2'b00);
    set_row(4,  5,  5, 1, 0, 0, 1,  0, 1, 2'b01); // period 13 -> range fault
    set_row(5,  5,  5, 5, 1, 1, 0,  1, 0, 2'b00); // clear, relock
    set_row(6,  5, 40, 1, 0, 0, 33, 0, 1, 2'b10); // held low -> loss
    set_row(7,  5,  5, 3, 0, 0, 0,  0, 1, 2'b10); // restart stays faulted
    set_row(8,  5,  5, 1, 1, 0, 0,  0, 0, 2'b00); // clear, first rise only
    set_row(9,  5,  4, 1, 0, 0, 0,  0, 0, 2'b00);
    set_row(10, 5,  6, 1, 0, 0, 0,  0, 0, 2'b00); // measures 9
    set_row(11, 6,  6, 1, 0, 0, 0,  0, 0, 2'b00); // measures 11
    set_row(12, 5,  5, 1, 0, 0, 0,  0, 0, 2'b00); // measures 12 -> count restarts
    set_row(13, 5,  5, 1, 0, 0, 0,  0, 0, 2'b00);
    set_row(14, 5,  5, 2, 0, 0, 0,  0, 0, 2'b00); // good=3
    set_row(15, 5,  5, 1, 0, 0, 0,  1, 0, 2'b00); // good=4 -> locked
    set_row(16, 7,  3, 1, 0, 0, 0,  1, 0, 2'b00);
`ifdef CLKMON_DUTY_EN
    set_row(17, 5,  5, 1, 0, 0, 1,  0, 1, 2'b11); // 7-high period -> duty fault
`else
    set_row(17, 5,  5, 1, 0, 0, 0,  1, 0, 2'b00);
`endif

    reset_n     = 1'b0;
    clk_in      = 1'b0;
    clear_fault = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    chk("reset_period", int'(period), 0);
    chk("reset_flags", int'({rise_pulse, fall_pulse, period_valid, locked, fault}), 0);
    chk("reset_code", int'(fault_code), 0);
    reset_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].lock5) begin
        rise_cnt  = 0;
        lock_seen = 0;
        rise5_cyc = -1000;
        lock_cyc  = -1000;
      end
      fault_cyc = -1000;
      drive_row(tbl[i].hi, tbl[i].lo, tbl[i].n, tbl[i].clr);
      chk($sformatf("row%0d_locked", i), int'(locked), int'(tbl[i].exp_locked));
      chk($sformatf("row%0d_fault", i), int'(fault), int'(tbl[i].exp_fault));
      chk($sformatf("row%0d_code", i), int'(fault_code), int'(tbl[i].exp_code));
      if (tbl[i].lock5)
        chk($sformatf("row%0d_lock_after_rise5", i), lock_cyc - rise5_cyc, 1);
      if (tbl[i].fdly > 0)
        chk($sformatf("row%0d_fault_delay", i), fault_cyc - fault_rp, tbl[i].fdly);
`ifdef CLKMON_DUTY_EN
      if (tbl[i].hi == 7) chk("high_time", int'(high_time), 7);
`endif
    end

    // Asynchronous reset in the middle of a high phase.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_period", int'(period), 0);
    chk("async_rst_flags", int'({rise_pulse, fall_pulse, period_valid, locked, fault}), 0);
    chk("async_rst_code", int'(fault_code), 0);
    repeat (3) step(1'b0, 1'b0);
    reset_n = 1'b1;
    sb.delete();
    pv_pend   = 0;
    last_drv  = -1;
    fall_drv  = 0;
    fall_seen = 0;
    repeat (3) step(1'b0, 1'b0);

    rise_cnt  = 0;
    lock_seen = 0;
    drive_row(5, 5, 5, 1'b0);
    chk("post_rst_locked", int'(locked), 1);
    chk("post_rst_lock_after_rise5", lock_cyc - rise5_cyc, 1);
    chk("post_rst_fault", int'(fault), 0);

    repeat (6) step(1'b0, 1'b0);
    chk("rises_all_seen", sb.size(), 0);
    chk("fall_count", fall_seen, fall_drv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
